// File: rtl/pipelined_decode_ctrl.sv
// ID/EX decode stage: decodes op/funct/rt into registered EX controls and
// sequences the HI/LO multiply/divide unit, stalling dependent instructions.
module pipelined_decode_ctrl #(
    parameter int ALUCTRL_W = 4,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 32,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic [4:0]           rt,
    input  logic                 stall_in,
    input  logic                 flush,
    output logic                 stall_out,
    output logic                 valid_e,
    output logic                 mem_to_reg,
    output logic                 mem_write,
    output logic                 branch,
    output logic                 alu_src,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 jump,
    output logic                 jump_r,
    output logic                 alu_a_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [2:0]           branch_op,
    output logic [2:0]           load_type,
    output logic [1:0]           save_type,
    output logic [1:0]           hilo_rd,
    output logic [1:0]           hilo_wr,
    output logic                 md_start,
    output logic [1:0]           md_op,
    output logic                 md_busy,
    output logic                 illegal
);

    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_NOR  = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_LUI  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(10);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(11);

    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_GTZ = 3'd1;
    localparam logic [2:0] BR_GEZ = 3'd2;
    localparam logic [2:0] BR_LTZ = 3'd3;
    localparam logic [2:0] BR_LEZ = 3'd4;
    localparam logic [2:0] BR_NE  = 3'd5;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic                 valid_e;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic                 branch;
        logic                 alu_src;
        logic                 reg_dst;
        logic                 reg_write;
        logic                 jump;
        logic                 jump_r;
        logic                 alu_a_src;
        logic [ALUCTRL_W-1:0] alu_control;
        logic [2:0]           branch_op;
        logic [2:0]           load_type;
        logic [1:0]           save_type;
        logic [1:0]           hilo_rd;
        logic [1:0]           hilo_wr;
        logic                 md_start;
        logic [1:0]           md_op;
        logic                 illegal;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} md_state_t;

    ctrl_t            dec;
    ctrl_t            ctrl_q;
    logic             dec_illegal;
    logic             is_md;
    logic             is_hilo;
    logic             accept;
    md_state_t        state_q;
    md_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // funct 18h-1Bh are the MD ops, 10h-13h the HI/LO moves
    assign is_md     = (op == 6'h00) && (funct[5:2] == 4'b0110);
    assign is_hilo   = (op == 6'h00) && (funct[5:2] == 4'b0100);
    assign stall_out = instr_valid && (state_q == BUSY) && (is_md || is_hilo);
    assign accept    = instr_valid && !stall_out && !stall_in && !flush;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (op)
            6'h00: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct)
                    6'h00: begin dec.alu_control = ALU_SLL; dec.alu_a_src = 1'b1; end
                    6'h02: begin dec.alu_control = ALU_SRL; dec.alu_a_src = 1'b1; end
                    6'h03: begin dec.alu_control = ALU_SRA; dec.alu_a_src = 1'b1; end
                    6'h04: dec.alu_control = ALU_SLL;
                    6'h06: dec.alu_control = ALU_SRL;
                    6'h07: dec.alu_control = ALU_SRA;
                    6'h08: begin
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                        dec.jump      = 1'b1;
                        dec.jump_r    = 1'b1;
                        dec.branch    = 1'b1;
                    end
                    6'h10: dec.hilo_rd = 2'b01;
                    6'h12: dec.hilo_rd = 2'b10;
                    6'h11, 6'h13: begin
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                        dec.hilo_wr   = funct[1] ? 2'b10 : 2'b01;
                    end
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                        dec.md_start  = 1'b1;
                        dec.md_op     = funct[1:0];
                    end
                    6'h20, 6'h21: dec.alu_control = ALU_ADD;
                    6'h22, 6'h23: dec.alu_control = ALU_SUB;
                    6'h24: dec.alu_control = ALU_AND;
                    6'h25: dec.alu_control = ALU_OR;
                    6'h26: dec.alu_control = ALU_XOR;
                    6'h27: dec.alu_control = ALU_NOR;
                    6'h2A: dec.alu_control = ALU_SLT;
                    6'h2B: dec.alu_control = ALU_SLTU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h01: begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                case (rt)
                    5'd0:    dec.branch_op = BR_LTZ;
                    5'd1:    dec.branch_op = BR_GEZ;
                    default: dec_illegal   = 1'b1;
                endcase
            end
            6'h02: dec.jump = 1'b1;
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                case (op[1:0])
                    2'd0:    dec.branch_op = BR_EQ;
                    2'd1:    dec.branch_op = BR_NE;
                    2'd2:    dec.branch_op = BR_LEZ;
                    default: dec.branch_op = BR_GTZ;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                case (op[2:0])
                    3'd0, 3'd1: dec.alu_control = ALU_ADD;
                    3'd2:       dec.alu_control = ALU_SLT;
                    3'd3:       dec.alu_control = ALU_SLTU;
                    3'd4:       dec.alu_control = ALU_AND;
                    3'd5:       dec.alu_control = ALU_OR;
                    3'd6:       dec.alu_control = ALU_XOR;
                    default:    dec.alu_control = ALU_LUI;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.mem_to_reg  = 1'b1;
                dec.reg_write   = 1'b1;
                case (op[2:0])
                    3'd0:    dec.load_type = 3'd3;
                    3'd1:    dec.load_type = 3'd1;
                    3'd4:    dec.load_type = 3'd4;
                    3'd5:    dec.load_type = 3'd2;
                    default: dec.load_type = 3'd0;
                endcase
            end
            6'h28, 6'h29, 6'h2B: begin
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.mem_write   = 1'b1;
                case (op[1:0])
                    2'd0:    dec.save_type = 2'd2;
                    2'd1:    dec.save_type = 2'd1;
                    default: dec.save_type = 2'd0;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal || !instr_valid) begin
            dec         = '0;
            dec.illegal = dec_illegal && instr_valid;
        end else begin
            dec.valid_e = 1'b1;
        end
    end

    // A held register must not replay the one-shot md_start/illegal pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (flush) begin
            ctrl_q <= '0;
        end else if (stall_in) begin
            ctrl_q.md_start <= 1'b0;
            ctrl_q.illegal  <= 1'b0;
        end else if (accept) begin
            ctrl_q <= dec;
        end else begin
            ctrl_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // BUSY runs to completion regardless of stall_in/flush
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && is_md) begin
                    state_d = BUSY;
                    cnt_d   = funct[1] ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy     = (state_q == BUSY);
    assign valid_e     = ctrl_q.valid_e;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign mem_write   = ctrl_q.mem_write;
    assign branch      = ctrl_q.branch;
    assign alu_src     = ctrl_q.alu_src;
    assign reg_dst     = ctrl_q.reg_dst;
    assign reg_write   = ctrl_q.reg_write;
    assign jump        = ctrl_q.jump;
    assign jump_r      = ctrl_q.jump_r;
    assign alu_a_src   = ctrl_q.alu_a_src;
    assign alu_control = ctrl_q.alu_control;
    assign branch_op   = ctrl_q.branch_op;
    assign load_type   = ctrl_q.load_type;
    assign save_type   = ctrl_q.save_type;
    assign hilo_rd     = ctrl_q.hilo_rd;
    assign hilo_wr     = ctrl_q.hilo_wr;
    assign md_start    = ctrl_q.md_start;
    assign md_op       = ctrl_q.md_op;
    assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// Directed bench for pipelined_decode_ctrl: decode tables, MD hazard timing,
// stall/flush priority and asynchronous reset, against hand-computed values.
module tb_pipelined_decode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       stall_in;
    logic       flush;
    logic       stall_out;
    logic       valid_e, mem_to_reg, mem_write, branch, alu_src, reg_dst;
    logic       reg_write, jump, jump_r, alu_a_src;
    logic [3:0] alu_control;
    logic [2:0] branch_op;
    logic [2:0] load_type;
    logic [1:0] save_type;
    logic [1:0] hilo_rd;
    logic [1:0] hilo_wr;
    logic       md_start;
    logic [1:0] md_op;
    logic       md_busy;
    logic       illegal;

    int checks      = 0;
    int failures    = 0;
    int busy_total  = 0;
    int busy_start  = 0;
    int stall_count = 0;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic [3:0] alu;
        logic [2:0] lt;
        logic [1:0] st;
        logic [6:0] flags;
    } row_t;

    row_t rows [11];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (md_busy) busy_total <= busy_total + 1;
    end

    pipelined_decode_ctrl #(
        .ALUCTRL_W(4), .MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .op(op),
        .funct(funct), .rt(rt), .stall_in(stall_in), .flush(flush),
        .stall_out(stall_out), .valid_e(valid_e), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .branch(branch), .alu_src(alu_src),
        .reg_dst(reg_dst), .reg_write(reg_write), .jump(jump),
        .jump_r(jump_r), .alu_a_src(alu_a_src), .alu_control(alu_control),
        .branch_op(branch_op), .load_type(load_type), .save_type(save_type),
        .hilo_rd(hilo_rd), .hilo_wr(hilo_wr), .md_start(md_start),
        .md_op(md_op), .md_busy(md_busy), .illegal(illegal)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] o, input logic [5:0] f,
                                 input logic [4:0] r, input logic si, input logic fl);
        instr_valid = v;
        op          = o;
        funct       = f;
        rt          = r;
        stall_in    = si;
        flush       = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && md_busy; i++) step();
        checkOutput("idle_timeout", {31'd0, md_busy}, 32'd0);
    endtask

    initial begin
        // flags = {mem_to_reg, mem_write, alu_src, alu_a_src, reg_dst, reg_write, valid_e}
        rows[0]  = '{6'h2B, 6'h00, 4'd1,  3'd0, 2'd0, 7'b0110001}; // sw
        rows[1]  = '{6'h28, 6'h00, 4'd1,  3'd0, 2'd2, 7'b0110001}; // sb
        rows[2]  = '{6'h25, 6'h00, 4'd1,  3'd2, 2'd0, 7'b1010011}; // lhu
        rows[3]  = '{6'h20, 6'h00, 4'd1,  3'd3, 2'd0, 7'b1010011}; // lb
        rows[4]  = '{6'h0F, 6'h00, 4'd8,  3'd0, 2'd0, 7'b0010011}; // lui
        rows[5]  = '{6'h0B, 6'h00, 4'd0,  3'd0, 2'd0, 7'b0010011}; // sltiu
        rows[6]  = '{6'h0E, 6'h00, 4'd5,  3'd0, 2'd0, 7'b0010011}; // xori
        rows[7]  = '{6'h00, 6'h27, 4'd6,  3'd0, 2'd0, 7'b0000111}; // nor
        rows[8]  = '{6'h00, 6'h23, 4'd2,  3'd0, 2'd0, 7'b0000111}; // subu
        rows[9]  = '{6'h00, 6'h03, 4'd10, 3'd0, 2'd0, 7'b0001111}; // sra
        rows[10] = '{6'h00, 6'h07, 4'd10, 3'd0, 2'd0, 7'b0000111}; // srav

        rst_n = 1'b0;
        applyStimulus(0, 6'h00, 6'h00, 5'd0, 0, 0);
        @(negedge clk);
        checkOutput("reset_valid_e", {31'd0, valid_e}, 32'd0);
        checkOutput("reset_md_busy", {31'd0, md_busy}, 32'd0);
        checkOutput("reset_alu_control", {28'd0, alu_control}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(1, rows[i].op, rows[i].funct, 5'd0, 0, 0);
            step();
            checkOutput($sformatf("table_row%0d", i),
                        {16'd0, alu_control, load_type, save_type, mem_to_reg, mem_write,
                         alu_src, alu_a_src, reg_dst, reg_write, valid_e},
                        {16'd0, rows[i].alu, rows[i].lt, rows[i].st, rows[i].flags});
        end

        applyStimulus(1, 6'h02, 6'h00, 5'd0, 0, 0);
        step();
        checkOutput("j_ctrl", {27'd0, jump, jump_r, branch, reg_write, valid_e}, 32'b10001);
        applyStimulus(1, 6'h00, 6'h08, 5'd0, 0, 0);
        step();
        checkOutput("jr_ctrl", {27'd0, jump, jump_r, branch, reg_write, valid_e}, 32'b11101);
        applyStimulus(1, 6'h01, 6'h00, 5'd1, 0, 0);
        step();
        checkOutput("bgez_ctrl", {28'd0, branch, branch_op}, 32'b1010);
        applyStimulus(1, 6'h05, 6'h00, 5'd0, 0, 0);
        step();
        checkOutput("bne_ctrl", {28'd0, branch, branch_op}, 32'b1101);
        applyStimulus(1, 6'h00, 6'h11, 5'd0, 0, 0);
        step();
        checkOutput("mthi_ctrl", {28'd0, hilo_wr, reg_write, valid_e}, 32'b0101);

        // MULT then MFLO: MFLO must wait out the four busy cycles
        busy_start = busy_total;
        applyStimulus(1, 6'h00, 6'h18, 5'd0, 0, 0);
        checkOutput("mult_no_stall_idle", {31'd0, stall_out}, 32'd0);
        step();
        checkOutput("mult_start", {29'd0, md_start, md_op}, 32'b100);
        checkOutput("mult_busy", {31'd0, md_busy}, 32'd1);
        applyStimulus(1, 6'h00, 6'h12, 5'd0, 0, 0);
        stall_count = 0;
        for (int i = 0; i < 20 && stall_out; i++) begin
            stall_count++;
            step();
            if (i == 0) checkOutput("mult_pulse_once", {31'd0, md_start}, 32'd0);
        end
        checkOutput("mult_stall_cycles", stall_count, 32'd4);
        checkOutput("mult_busy_dropped", {31'd0, md_busy}, 32'd0);
        checkOutput("mult_busy_total", busy_total - busy_start, 32'd4);
        step();
        checkOutput("mflo_out", {27'd0, hilo_rd, reg_write, reg_dst, valid_e}, 32'b10111);

        // DIV then independent instructions issue without stalling
        busy_start = busy_total;
        applyStimulus(1, 6'h00, 6'h1A, 5'd0, 0, 0);
        step();
        checkOutput("div_start", {29'd0, md_start, md_op}, 32'b110);
        applyStimulus(1, 6'h08, 6'h00, 5'd0, 0, 0);
        checkOutput("addi_no_stall", {31'd0, stall_out}, 32'd0);
        step();
        checkOutput("addi_ctrl", {26'd0, alu_control, alu_src, valid_e}, 32'b000111);
        applyStimulus(1, 6'h23, 6'h00, 5'd0, 0, 0);
        checkOutput("lw_no_stall", {31'd0, stall_out}, 32'd0);
        step();
        checkOutput("lw_ctrl", {27'd0, load_type, mem_to_reg, valid_e}, 32'b00011);
        applyStimulus(1, 6'h04, 6'h00, 5'd0, 0, 0);
        checkOutput("beq_no_stall", {31'd0, stall_out}, 32'd0);
        step();
        checkOutput("beq_ctrl", {27'd0, branch, branch_op, valid_e}, 32'b10001);
        applyStimulus(0, 6'h00, 6'h00, 5'd0, 0, 0);
        waitIdle();
        checkOutput("div_busy_total", busy_total - busy_start, 32'd32);

        // Undecodable REGIMM and unknown funct
        applyStimulus(1, 6'h01, 6'h00, 5'd3, 0, 0);
        step();
        checkOutput("regimm_illegal", {30'd0, valid_e, illegal}, 32'b01);
        applyStimulus(0, 6'h00, 6'h00, 5'd0, 0, 0);
        step();
        checkOutput("illegal_clears", {31'd0, illegal}, 32'd0);
        applyStimulus(1, 6'h00, 6'h01, 5'd0, 0, 0);
        step();
        checkOutput("funct_illegal", {30'd0, valid_e, illegal}, 32'b01);

        // flush beats stall_in even over a held sll
        applyStimulus(1, 6'h00, 6'h00, 5'd0, 0, 0);
        step();
        checkOutput("sll_ctrl", {27'd0, alu_control, alu_a_src}, 32'b10011);
        applyStimulus(1, 6'h00, 6'h04, 5'd0, 1, 1);
        step();
        checkOutput("flush_bubble", {26'd0, alu_control, alu_a_src, valid_e}, 32'd0);
        applyStimulus(1, 6'h00, 6'h04, 5'd0, 0, 0);
        step();
        checkOutput("sllv_ctrl", {25'd0, alu_control, alu_a_src, reg_dst, valid_e}, 32'b1001011);

        // MULTU held by stall_in: single md_start pulse, counter keeps running
        busy_start = busy_total;
        applyStimulus(1, 6'h00, 6'h19, 5'd0, 0, 0);
        step();
        checkOutput("multu_start", {29'd0, md_start, md_op}, 32'b101);
        applyStimulus(0, 6'h00, 6'h00, 5'd0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("multu_hold%0d", i),
                        {28'd0, valid_e, md_start, md_op}, 32'b1001);
        end
        applyStimulus(0, 6'h00, 6'h00, 5'd0, 0, 0);
        step();
        checkOutput("multu_release", {30'd0, valid_e, md_busy}, 32'd0);
        checkOutput("multu_busy_total", busy_total - busy_start, 32'd4);

        // Asynchronous reset while DIV is mid-flight (counter at 20)
        applyStimulus(1, 6'h00, 6'h1A, 5'd0, 0, 0);
        step();
        applyStimulus(0, 6'h00, 6'h00, 5'd0, 0, 0);
        for (int i = 0; i < 11; i++) step();
        applyStimulus(1, 6'h08, 6'h00, 5'd0, 0, 0);
        step();
        checkOutput("pre_reset", {29'd0, valid_e, alu_src, md_busy}, 32'b111);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {28'd0, valid_e, alu_src, reg_write, md_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 6'h00, 6'h12, 5'd0, 0, 0);
        checkOutput("post_reset_no_stall", {31'd0, stall_out}, 32'd0);
        step();
        checkOutput("post_reset_mflo", {29'd0, hilo_rd, valid_e}, 32'b101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
